reservation_station: RTL and testbench
======================================

Name: reservation_station

Overview:
- Tomasulo reservation station between the dispatcher and one functional unit.
- Holds dispatched instructions until both operands are available, capturing values from CDB broadcasts.
- Issues the oldest ready entry to the FU; age is measured relative to the ROB head.
- The FU result returns over the CDB to the reorder buffer under the same ROB tag.

Parameters:
- RS_SIZE, 4: number of entries; power of two, at least 2.
- RS_IDX_LEN, $clog2(RS_SIZE): entry index width.
- ROB_TAG_LEN, `ROB_TAG_LEN: ROB tag width, taken from sys_defs.
- XLEN, `XLEN: operand width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous reset, active-low.
- dispatch  in  1  allocate an entry this cycle.
- op_from_dispatcher  in  ALU_FUNC  operation code.
- src1_ready_from_dispatcher  in  1  src1 value is already valid.
- src1_tag_from_dispatcher  in  ROB_TAG_LEN  producer tag when src1 is not ready.
- src1_val_from_dispatcher  in  XLEN  src1 value when ready.
- src2_ready_from_dispatcher, src2_tag_from_dispatcher, src2_val_from_dispatcher  in  1/ROB_TAG_LEN/XLEN  same as src1.
- dest_tag_from_dispatcher  in  ROB_TAG_LEN  ROB tag assigned to the instruction.
- pc_from_dispatcher, npc_from_dispatcher  in  XLEN  instruction PC and NPC.
- rob_head_tag  in  ROB_TAG_LEN  current ROB head, used for age ordering.
- cdb_valid  in  1  CDB broadcast valid.
- cdb_tag  in  ROB_TAG_LEN  broadcast tag.
- cdb_data  in  XLEN  broadcast value.
- flush  in  1  mispredict flush from the ROB.
- fu_ready  in  1  FU accepts an issue this cycle.
- rs_full  out  1  no free entry.
- issue_valid  out  1  issue operands valid.
- issue_op  out  ALU_FUNC  operation code of the issued entry.
- issue_src1, issue_src2  out  XLEN  operand values.
- issue_dest_tag  out  ROB_TAG_LEN  ROB tag of the issued entry.
- issue_pc, issue_npc  out  XLEN  PC and NPC of the issued entry.

Behaviour:
- Reset (reset==0, asynchronous):
  - All entries are invalid and all fields zero.
  - rs_full=0, issue_valid=0, all issue_* outputs zero.
- Allocation:
  - On dispatch && !rs_full, write the lowest-index invalid entry at the clock edge.
  - dispatch while rs_full is ignored and leaves state unchanged. The dispatcher must not do this.
  - A slot freed by an issue in the same cycle is not visible to allocation until the next cycle.
- Dispatch/CDB same cycle: if cdb_valid and cdb_tag equals a not-ready source tag of the dispatching instruction, that source is written as ready with value cdb_data.
- Wakeup:
  - Every valid entry with a not-ready source whose tag equals cdb_tag captures cdb_data and sets ready at the edge.
  - Both sources of one entry may wake in the same cycle.
- Ready rule: an entry is ready when it is valid and both sources are ready.
- Select (combinational):
  - Choose the ready entry with the minimum (dest_tag - rob_head_tag) modulo 2^ROB_TAG_LEN; this handles ROB wrap-around.
  - Ties cannot occur because ROB tags are unique.
  - issue_valid=1 when any entry is ready; issue_* carry the selected entry's fields. When issue_valid=0, issue_* are zero.
- Issue handshake:
  - When issue_valid && fu_ready, the selected entry is invalidated at the edge.
  - When issue_valid && !fu_ready, the same entry is held. The selection may change next cycle if an older entry becomes ready.
- Latency: without the optional feature, an operand woken at edge N can issue in the cycle after edge N. Minimum dispatch-to-issue time is 1 cycle.
- rs_full = (count of valid entries == RS_SIZE), computed from registered state.
- Flush:
  - Synchronous; takes priority over dispatch, wakeup and issue.
  - All entries are invalid after the edge.
  - issue_valid is still combinationally driven during the flush cycle; the FU discards that issue.
- Reset mid-operation clears everything immediately, independent of clk.

Optional Feature:
- Macro: RS_WAKEUP_BYPASS_EN.
- Defined:
  - An entry whose only missing operands match the current cdb_tag counts as ready in the same cycle.
  - Its issue operand is muxed from cdb_data, giving back-to-back dependent issue.
  - The entry is invalidated if fu_ready. If not, it captures the value as a normal wakeup.
- Undefined: wakeup only takes effect at the edge, as specified under Behaviour.

Decomposition:
- sys_defs.svh holds:
  - RS_ENTRY struct: valid, op, src1_ready, src1_tag, src1_val, src2_ready, src2_tag, src2_val, dest_tag, pc, npc.
  - ALU_FUNC enum.
  - `RS_SIZE default.
- Sub-module rs_age_select: purely combinational. Takes ready[RS_SIZE], dest_tag[RS_SIZE] and rob_head_tag; outputs sel_valid and sel_idx.

Test Plan:
1. Reset then dispatch op=ADD, src1 ready 5, src2 ready 7, tag 3, fu_ready=1:
   - Next cycle issue_valid=1, src1=5, src2=7, dest=3.
   - The following cycle issue_valid=0.
2. Dispatch tag 2 with src1 waiting on tag 1; CDB tag 1 data 0x10 two cycles later:
   - Issue occurs the cycle after the broadcast edge with issue_src1=0x10.
   - With RS_WAKEUP_BYPASS_EN, issue occurs in the broadcast cycle.
3. rob_head_tag=6, ROB_TAG_LEN=3; ready entries with tags 7 and 1:
   - Tag 7 issues first, then tag 1 (wrap-around age).
4. Fill 4 entries with unready sources:
   - rs_full=1; a 5th dispatch is ignored and entry contents are unchanged.
   - One issue then drops rs_full the next cycle.
5. Dispatch with src2 waiting on tag 4 while CDB broadcasts tag 4 data 0x99 in the same cycle:
   - The entry is stored ready and issues next cycle with src2=0x99.
6. Two ready entries with fu_ready=0 for 3 cycles, then flush=1:
   - issue_* stay stable while stalled; after flush, issue_valid=0 and rs_full=0.
   - Asserting reset=0 asynchronously mid-cycle clears issue_valid immediately.

Source files
------------

// File: rtl/reservation_station_pkg.sv
// Shared system definitions and types for the reservation station: XLEN / ROB tag width / RS depth
// defaults, the ALU opcode enum and the per-entry record.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 3
`endif
`ifndef RS_SIZE
`define RS_SIZE 4
`endif

package reservation_station_pkg;
    localparam int XLEN        = `XLEN;
    localparam int ROB_TAG_LEN = `ROB_TAG_LEN;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } ALU_FUNC;

    typedef struct packed {
        logic                   valid;
        ALU_FUNC                op;
        logic                   src1_ready;
        logic [ROB_TAG_LEN-1:0] src1_tag;
        logic [XLEN-1:0]        src1_val;
        logic                   src2_ready;
        logic [ROB_TAG_LEN-1:0] src2_tag;
        logic [XLEN-1:0]        src2_val;
        logic [ROB_TAG_LEN-1:0] dest_tag;
        logic [XLEN-1:0]        pc;
        logic [XLEN-1:0]        npc;
    } RS_ENTRY;
endpackage

// File: rtl/reservation_station_rs_age_select.sv
// Combinational oldest-ready picker: age is the dest tag distance from the ROB head,
// taken modulo the tag space so ROB wrap-around orders correctly.
module rs_age_select
    import reservation_station_pkg::*;
#(
    parameter int RS_SIZE    = 4,
    parameter int RS_IDX_LEN = $clog2(RS_SIZE)
) (
    input  logic [RS_SIZE-1:0]     ready,
    input  logic [ROB_TAG_LEN-1:0] dest_tag [RS_SIZE],
    input  logic [ROB_TAG_LEN-1:0] rob_head_tag,
    output logic                   sel_valid,
    output logic [RS_IDX_LEN-1:0]  sel_idx
);
    logic [ROB_TAG_LEN-1:0] age [RS_SIZE];
    logic [ROB_TAG_LEN-1:0] best_age;

    for (genvar gi = 0; gi < RS_SIZE; gi++) begin : g_age
        assign age[gi] = dest_tag[gi] - rob_head_tag;
    end

    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        best_age  = '1;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (ready[i] && (!sel_valid || age[i] < best_age)) begin
                sel_valid = 1'b1;
                sel_idx   = RS_IDX_LEN'(i);
                best_age  = age[i];
            end
        end
    end
endmodule

// File: rtl/reservation_station.sv
// Tomasulo reservation station feeding one FU: CDB wakeup, oldest-first issue, flush.
// Optional same-cycle CDB bypass into issue is enabled by defining RS_WAKEUP_BYPASS_EN.
module reservation_station
    import reservation_station_pkg::*;
#(
    parameter int RS_SIZE    = `RS_SIZE,
    parameter int RS_IDX_LEN = $clog2(RS_SIZE)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   dispatch,
    input  ALU_FUNC                op_from_dispatcher,
    input  logic                   src1_ready_from_dispatcher,
    input  logic [ROB_TAG_LEN-1:0] src1_tag_from_dispatcher,
    input  logic [XLEN-1:0]        src1_val_from_dispatcher,
    input  logic                   src2_ready_from_dispatcher,
    input  logic [ROB_TAG_LEN-1:0] src2_tag_from_dispatcher,
    input  logic [XLEN-1:0]        src2_val_from_dispatcher,
    input  logic [ROB_TAG_LEN-1:0] dest_tag_from_dispatcher,
    input  logic [XLEN-1:0]        pc_from_dispatcher,
    input  logic [XLEN-1:0]        npc_from_dispatcher,
    input  logic [ROB_TAG_LEN-1:0] rob_head_tag,
    input  logic                   cdb_valid,
    input  logic [ROB_TAG_LEN-1:0] cdb_tag,
    input  logic [XLEN-1:0]        cdb_data,
    input  logic                   flush,
    input  logic                   fu_ready,
    output logic                   rs_full,
    output logic                   issue_valid,
    output ALU_FUNC                issue_op,
    output logic [XLEN-1:0]        issue_src1,
    output logic [XLEN-1:0]        issue_src2,
    output logic [ROB_TAG_LEN-1:0] issue_dest_tag,
    output logic [XLEN-1:0]        issue_pc,
    output logic [XLEN-1:0]        issue_npc
);
    RS_ENTRY rs_reg  [RS_SIZE];
    RS_ENTRY rs_next [RS_SIZE];
    RS_ENTRY sel_entry;
    RS_ENTRY new_entry;

    logic [RS_SIZE-1:0]     valid_vec, s1_hit, s2_hit, s1_ok, s2_ok, entry_ready;
    logic [ROB_TAG_LEN-1:0] dest_tags [RS_SIZE];
    logic                   sel_valid, issue_fire;
    logic [RS_IDX_LEN-1:0]  sel_idx, free_idx;

    for (genvar gi = 0; gi < RS_SIZE; gi++) begin : g_entry
        assign valid_vec[gi] = rs_reg[gi].valid;
        assign dest_tags[gi] = rs_reg[gi].dest_tag;
        assign s1_hit[gi] = cdb_valid && !rs_reg[gi].src1_ready && (rs_reg[gi].src1_tag == cdb_tag);
        assign s2_hit[gi] = cdb_valid && !rs_reg[gi].src2_ready && (rs_reg[gi].src2_tag == cdb_tag);
`ifdef RS_WAKEUP_BYPASS_EN
        assign s1_ok[gi] = rs_reg[gi].src1_ready || s1_hit[gi];
        assign s2_ok[gi] = rs_reg[gi].src2_ready || s2_hit[gi];
`else
        assign s1_ok[gi] = rs_reg[gi].src1_ready;
        assign s2_ok[gi] = rs_reg[gi].src2_ready;
`endif
        assign entry_ready[gi] = rs_reg[gi].valid && s1_ok[gi] && s2_ok[gi];
    end

    rs_age_select #(.RS_SIZE(RS_SIZE), .RS_IDX_LEN(RS_IDX_LEN)) u_age_select (
        .ready        (entry_ready),
        .dest_tag     (dest_tags),
        .rob_head_tag (rob_head_tag),
        .sel_valid    (sel_valid),
        .sel_idx      (sel_idx)
    );

    assign rs_full     = &valid_vec;
    assign issue_valid = sel_valid;
    assign issue_fire  = sel_valid && fu_ready;
    assign sel_entry   = rs_reg[sel_idx];

    always_comb begin
        issue_op       = ALU_ADD;
        issue_src1     = '0;
        issue_src2     = '0;
        issue_dest_tag = '0;
        issue_pc       = '0;
        issue_npc      = '0;
        if (sel_valid) begin
            issue_op       = sel_entry.op;
            issue_src1     = sel_entry.src1_val;
            issue_src2     = sel_entry.src2_val;
            issue_dest_tag = sel_entry.dest_tag;
            issue_pc       = sel_entry.pc;
            issue_npc      = sel_entry.npc;
`ifdef RS_WAKEUP_BYPASS_EN
            if (!sel_entry.src1_ready) issue_src1 = cdb_data;
            if (!sel_entry.src2_ready) issue_src2 = cdb_data;
`endif
        end
    end

    // Lowest-index free slot, from registered state only.
    always_comb begin
        free_idx = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!rs_reg[i].valid) free_idx = RS_IDX_LEN'(i);
        end
    end

    always_comb begin
        new_entry            = '0;
        new_entry.valid      = 1'b1;
        new_entry.op         = op_from_dispatcher;
        new_entry.src1_ready = src1_ready_from_dispatcher;
        new_entry.src1_tag   = src1_tag_from_dispatcher;
        new_entry.src1_val   = src1_val_from_dispatcher;
        new_entry.src2_ready = src2_ready_from_dispatcher;
        new_entry.src2_tag   = src2_tag_from_dispatcher;
        new_entry.src2_val   = src2_val_from_dispatcher;
        new_entry.dest_tag   = dest_tag_from_dispatcher;
        new_entry.pc         = pc_from_dispatcher;
        new_entry.npc        = npc_from_dispatcher;
        if (cdb_valid && !src1_ready_from_dispatcher && src1_tag_from_dispatcher == cdb_tag) begin
            new_entry.src1_ready = 1'b1;
            new_entry.src1_val   = cdb_data;
        end
        if (cdb_valid && !src2_ready_from_dispatcher && src2_tag_from_dispatcher == cdb_tag) begin
            new_entry.src2_ready = 1'b1;
            new_entry.src2_val   = cdb_data;
        end
    end

    // Issue invalidation wins over wakeup; the dispatch slot is always a different, free entry.
    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            rs_next[i] = rs_reg[i];
            if (rs_reg[i].valid) begin
                if (s1_hit[i]) begin
                    rs_next[i].src1_ready = 1'b1;
                    rs_next[i].src1_val   = cdb_data;
                end
                if (s2_hit[i]) begin
                    rs_next[i].src2_ready = 1'b1;
                    rs_next[i].src2_val   = cdb_data;
                end
            end
            if (issue_fire && sel_idx == RS_IDX_LEN'(i)) rs_next[i] = '0;
            if (dispatch && !rs_full && free_idx == RS_IDX_LEN'(i)) rs_next[i] = new_entry;
            if (flush) rs_next[i] = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < RS_SIZE; i++) rs_reg[i] <= '0;
        end else begin
            rs_reg <= rs_next;
        end
    end
endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station with hand-computed expectations;
// expectations differ where RS_WAKEUP_BYPASS_EN changes wakeup timing.
module tb_reservation_station;
    import reservation_station_pkg::*;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   dispatch;
    ALU_FUNC                op_d;
    logic                   s1r, s2r;
    logic [ROB_TAG_LEN-1:0] s1t, s2t, dtag;
    logic [XLEN-1:0]        s1v, s2v, pc_d, npc_d;
    logic [ROB_TAG_LEN-1:0] rob_head_tag;
    logic                   cdb_valid;
    logic [ROB_TAG_LEN-1:0] cdb_tag;
    logic [XLEN-1:0]        cdb_data;
    logic                   flush, fu_ready;
    logic                   rs_full, issue_valid;
    ALU_FUNC                issue_op;
    logic [XLEN-1:0]        issue_src1, issue_src2, issue_pc, issue_npc;
    logic [ROB_TAG_LEN-1:0] issue_dest_tag;

    int vectors = 0;
    int miscompares = 0;

    reservation_station dut (
        .clk                        (clk),
        .reset                      (reset),
        .dispatch                   (dispatch),
        .op_from_dispatcher         (op_d),
        .src1_ready_from_dispatcher (s1r),
        .src1_tag_from_dispatcher   (s1t),
        .src1_val_from_dispatcher   (s1v),
        .src2_ready_from_dispatcher (s2r),
        .src2_tag_from_dispatcher   (s2t),
        .src2_val_from_dispatcher   (s2v),
        .dest_tag_from_dispatcher   (dtag),
        .pc_from_dispatcher         (pc_d),
        .npc_from_dispatcher        (npc_d),
        .rob_head_tag               (rob_head_tag),
        .cdb_valid                  (cdb_valid),
        .cdb_tag                    (cdb_tag),
        .cdb_data                   (cdb_data),
        .flush                      (flush),
        .fu_ready                   (fu_ready),
        .rs_full                    (rs_full),
        .issue_valid                (issue_valid),
        .issue_op                   (issue_op),
        .issue_src1                 (issue_src1),
        .issue_src2                 (issue_src2),
        .issue_dest_tag             (issue_dest_tag),
        .issue_pc                   (issue_pc),
        .issue_npc                  (issue_npc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic dsp(input ALU_FUNC op, input logic r1, input logic [ROB_TAG_LEN-1:0] t1,
                       input logic [XLEN-1:0] v1, input logic r2, input logic [ROB_TAG_LEN-1:0] t2,
                       input logic [XLEN-1:0] v2, input logic [ROB_TAG_LEN-1:0] d);
        dispatch = 1'b1; op_d = op;
        s1r = r1; s1t = t1; s1v = v1;
        s2r = r2; s2t = t2; s2v = v2;
        dtag = d; pc_d = 32'h1000 + 32'(d) * 4; npc_d = 32'h1004 + 32'(d) * 4;
    endtask

    initial begin
        reset = 1'b0; dispatch = 1'b0; op_d = ALU_ADD;
        s1r = 0; s1t = 0; s1v = 0; s2r = 0; s2t = 0; s2v = 0; dtag = 0; pc_d = 0; npc_d = 0;
        rob_head_tag = 0; cdb_valid = 0; cdb_tag = 0; cdb_data = 0; flush = 0; fu_ready = 1;
        #12;
        chk("reset_full", 32'(rs_full), 0);
        chk("reset_issue_valid", 32'(issue_valid), 0);
        chk("reset_src1", issue_src1, 0);
        reset = 1'b1;

        // 1: ready-on-dispatch issues the next cycle
        dsp(ALU_ADD, 1, 0, 5, 1, 0, 7, 3);
        tick(); dispatch = 0; #1;
        chk("t1_valid", 32'(issue_valid), 1);
        chk("t1_op", 32'(issue_op), 32'(ALU_ADD));
        chk("t1_src1", issue_src1, 5);
        chk("t1_src2", issue_src2, 7);
        chk("t1_dest", 32'(issue_dest_tag), 3);
        chk("t1_pc", issue_pc, 32'h100c);
        tick();
        chk("t1_gone", 32'(issue_valid), 0);

        // 2: wakeup on CDB
        dsp(ALU_SUB, 0, 1, 0, 1, 0, 32'h20, 2);
        tick(); dispatch = 0; #1;
        chk("t2_wait", 32'(issue_valid), 0);
        tick();
        cdb_valid = 1; cdb_tag = 1; cdb_data = 32'h10; #1;
`ifdef RS_WAKEUP_BYPASS_EN
        chk("t2_byp_valid", 32'(issue_valid), 1);
        chk("t2_byp_src1", issue_src1, 32'h10);
        tick(); cdb_valid = 0; #1;
        chk("t2_byp_gone", 32'(issue_valid), 0);
`else
        chk("t2_not_yet", 32'(issue_valid), 0);
        tick(); cdb_valid = 0; #1;
        chk("t2_valid", 32'(issue_valid), 1);
        chk("t2_src1", issue_src1, 32'h10);
        chk("t2_src2", issue_src2, 32'h20);
        chk("t2_dest", 32'(issue_dest_tag), 2);
        tick();
        chk("t2_gone", 32'(issue_valid), 0);
`endif

        // 3: wrap-around age with head 6
        rob_head_tag = 6; fu_ready = 0;
        dsp(ALU_AND, 1, 0, 32'h71, 1, 0, 32'h72, 1);
        tick();
        dsp(ALU_OR, 1, 0, 32'h77, 1, 0, 32'h78, 7);
        tick(); dispatch = 0; #1;
        chk("t3_first", 32'(issue_dest_tag), 7);
        chk("t3_first_src1", issue_src1, 32'h77);
        fu_ready = 1;
        tick();
        chk("t3_second", 32'(issue_dest_tag), 1);
        chk("t3_second_op", 32'(issue_op), 32'(ALU_OR) - 1);
        tick();
        chk("t3_empty", 32'(issue_valid), 0);

        // 4: fill, ignored 5th dispatch, drain one
        rob_head_tag = 0;
        dsp(ALU_ADD, 0, 5, 0, 1, 0, 32'h100, 0); tick();
        dsp(ALU_ADD, 0, 6, 0, 1, 0, 32'h101, 1); tick();
        dsp(ALU_ADD, 0, 6, 0, 1, 0, 32'h102, 2); tick();
        dsp(ALU_ADD, 0, 6, 0, 1, 0, 32'h103, 3); tick();
        chk("t4_full", 32'(rs_full), 1);
        dsp(ALU_XOR, 1, 0, 32'hAA, 1, 0, 32'hAA, 4); tick(); dispatch = 0; #1;
        chk("t4_still_full", 32'(rs_full), 1);
        chk("t4_no_issue", 32'(issue_valid), 0);
        cdb_valid = 1; cdb_tag = 5; cdb_data = 32'h55; #1;
`ifdef RS_WAKEUP_BYPASS_EN
        chk("t4_byp_valid", 32'(issue_valid), 1);
        chk("t4_byp_src1", issue_src1, 32'h55);
        tick(); cdb_valid = 0; #1;
`else
        chk("t4_no_issue_yet", 32'(issue_valid), 0);
        tick(); cdb_valid = 0; #1;
        chk("t4_issue_dest", 32'(issue_dest_tag), 0);
        chk("t4_issue_src1", issue_src1, 32'h55);
        chk("t4_issue_src2", issue_src2, 32'h100);
        chk("t4_full_before", 32'(rs_full), 1);
        tick();
`endif
        chk("t4_not_full", 32'(rs_full), 0);
        chk("t4_idle", 32'(issue_valid), 0);
        fu_ready = 0;
        cdb_valid = 1; cdb_tag = 6; cdb_data = 32'h66; #1;
`ifndef RS_WAKEUP_BYPASS_EN
        tick(); cdb_valid = 0; #1;
`endif
        chk("t4_oldest_dest", 32'(issue_dest_tag), 1);
        chk("t4_oldest_src2", issue_src2, 32'h101);
        chk("t4_oldest_src1", issue_src1, 32'h66);
        cdb_valid = 0; flush = 1;
        tick(); flush = 0; fu_ready = 1; #1;
        chk("t4_flushed", 32'(issue_valid), 0);

        // 5: dispatch and CDB in the same cycle
        dsp(ALU_SLT, 1, 0, 32'h1, 0, 4, 0, 5);
        cdb_valid = 1; cdb_tag = 4; cdb_data = 32'h99;
        tick(); dispatch = 0; cdb_valid = 0; #1;
        chk("t5_valid", 32'(issue_valid), 1);
        chk("t5_src2", issue_src2, 32'h99);
        chk("t5_dest", 32'(issue_dest_tag), 5);
        tick();
        chk("t5_gone", 32'(issue_valid), 0);

        // 6: stall, flush, async reset
        fu_ready = 0;
        dsp(ALU_ADD, 1, 0, 32'h11, 1, 0, 32'h22, 2); tick();
        dsp(ALU_ADD, 1, 0, 32'h33, 1, 0, 32'h44, 1); tick(); dispatch = 0; #1;
        for (int c = 0; c < 3; c++) begin
            chk("t6_stall_dest", 32'(issue_dest_tag), 1);
            chk("t6_stall_src1", issue_src1, 32'h33);
            if (c < 2) tick();
        end
        flush = 1; #1;
        chk("t6_flush_cycle_valid", 32'(issue_valid), 1);
        tick(); flush = 0; #1;
        chk("t6_after_flush_valid", 32'(issue_valid), 0);
        chk("t6_after_flush_full", 32'(rs_full), 0);
        dsp(ALU_ADD, 1, 0, 32'h5, 1, 0, 32'h6, 3);
        tick(); dispatch = 0; #1;
        chk("t6_pre_reset_valid", 32'(issue_valid), 1);
        #1 reset = 1'b0;
        #1;
        chk("t6_async_reset_valid", 32'(issue_valid), 0);
        chk("t6_async_reset_src1", issue_src1, 0);
        tick();
        reset = 1'b1;
        tick();
        chk("t6_post_reset_valid", 32'(issue_valid), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
